// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator behind a 4-word register window; reads and writes acknowledge 1 cycle after acceptance.
// No backpressure: a new access is accepted only after enable_in has been seen low; STEP timing is fixed by PERIOD/DIR_SETUP.
module step_pulse_gen #(
    parameter int unsigned DIR_SETUP    = 25,
    parameter int unsigned PERIOD_RESET = 12500,
    parameter int unsigned PERIOD_MIN   = 2
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        enable_in,
    input  logic        write_in,
    input  logic [1:0]  addr_in,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready_out,
    output logic        step_out,
    output logic        dir_out,
    output logic        drv_en_out
);

    localparam logic [31:0] SETUP_C = 32'(DIR_SETUP);
    localparam logic [31:0] PMIN_C  = 32'(PERIOD_MIN);
    localparam logic [31:0] PRST_C  = 32'(PERIOD_RESET);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PERIOD = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_HIGH  = 2'd2,
        S_LOW   = 2'd3
    } state_t;

    state_t      state_q,  state_d;
    logic [31:0] phase_q,  phase_d;
    logic [31:0] count_q,  count_d;
    logic [31:0] period_q, period_d;
    logic        en_q,     en_d;
    logic        cdir_q,   cdir_d;
    logic        dir_q,    dir_d;
    logic        done_q,   done_d;
    logic        lock_q,   lock_d;
    logic        ready_q,  ready_d;
    logic [31:0] rdata_q,  rdata_d;

    logic        accept;
    logic        wr_acc;
    logic        rd_acc;
    logic        start_stb;
    logic        stop_stb;
    logic        busy;
    logic [31:0] reload;

    // lock_q remembers enable_in from the previous cycle, so acceptance is its rising edge
    assign accept    = enable_in && !lock_q;
    assign wr_acc    = accept && write_in;
    assign rd_acc    = accept && !write_in;
    assign start_stb = wr_acc && (addr_in == A_CTRL) && data_in[2];
    assign stop_stb  = wr_acc && (addr_in == A_CTRL) && data_in[3];
    assign busy      = (state_q != S_IDLE);
    assign reload    = ((period_q < PMIN_C) ? PMIN_C : period_q) - 32'd1;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        count_d  = count_q;
        period_d = period_q;
        en_d     = en_q;
        cdir_d   = cdir_q;
        dir_d    = dir_q;
        done_d   = done_q;
        lock_d   = enable_in;
        ready_d  = accept;
        rdata_d  = 32'd0;

        if (rd_acc) begin
            case (addr_in)
                A_CTRL:   rdata_d = {30'd0, cdir_q, en_q};
                A_PERIOD: rdata_d = period_q;
                A_COUNT:  rdata_d = count_q;
                default:  rdata_d = {30'd0, done_q, busy};
            endcase
        end

        if (wr_acc) begin
            case (addr_in)
                A_CTRL: begin
                    en_d   = data_in[0];
                    cdir_d = data_in[1];
                end
                A_PERIOD: period_d = data_in;
                A_COUNT: begin
                    if (!busy) begin
                        count_d = data_in;
                    end
                end
                A_STATUS: ;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start_stb && !stop_stb) begin
                    if (count_q != 32'd0) begin
                        state_d = S_SETUP;
                        phase_d = SETUP_C;
                        done_d  = 1'b0;
                        dir_d   = data_in[1];
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (phase_q == 32'd0) begin
                    state_d = S_HIGH;
                    phase_d = reload;
                end else begin
                    phase_d = phase_q - 32'd1;
                end
            end
            S_HIGH: begin
                if (phase_q == 32'd0) begin
                    state_d = S_LOW;
                    phase_d = reload;
                    count_d = count_q - 32'd1;
                end else begin
                    phase_d = phase_q - 32'd1;
                end
            end
            S_LOW: begin
                if (phase_q == 32'd0) begin
                    if (count_q != 32'd0) begin
                        state_d = S_HIGH;
                        phase_d = reload;
                    end else begin
                        state_d = S_IDLE;
                        phase_d = 32'd0;
                        done_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q - 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = 32'd0;
            end
        endcase

        // stop aborts a run without touching the remaining step count
        if (stop_stb && busy) begin
            state_d = S_IDLE;
            phase_d = 32'd0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state_q  <= S_IDLE;
            phase_q  <= 32'd0;
            count_q  <= 32'd0;
            period_q <= PRST_C;
            en_q     <= 1'b0;
            cdir_q   <= 1'b0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
            lock_q   <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            count_q  <= count_d;
            period_q <= period_d;
            en_q     <= en_d;
            cdir_q   <= cdir_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            lock_q   <= lock_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
        end
    end

    assign step_out   = (state_q == S_HIGH);
    assign dir_out    = dir_q;
    assign drv_en_out = en_q;
    assign ready_out  = ready_q;
    assign data_out   = rdata_q;

endmodule
